// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int DEF_NUM_STAGES  = 4;
    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_GAP_CYCLES  = 4;
    localparam int DEF_CNT_W       = 8;

    // stage_idx must be able to hold NUM_STAGES itself (the idle value).
    function automatic int stage_idx_w(input int num_stages);
        return $clog2(num_stages) + 1;
    endfunction

endpackage

// File: rtl/tc_counter.sv
// Interval counter with synchronous clear/enable and a terminal-count flag.
module tc_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] count,
    output logic             at_term
);

    // Count up while enabled; reset and clear both return to zero.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset || clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign at_term = (count == term);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all downstream domains in reset, then releases them
// one at a time (lowest index first) with a fixed gap, ending in a done pulse.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES  = DEF_NUM_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 sw_rst_req,
    output logic [NUM_STAGES-1:0]                rst_out,
    output logic                                 busy,
    output logic                                 done,
    output logic [stage_idx_w(NUM_STAGES)-1:0]   stage_idx
);

    localparam int IDX_W     = stage_idx_w(NUM_STAGES);
    localparam int CNT_MAX_I = ((HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES) - 1;

    localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CNT_MAX_I);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STAGES - 1);
    localparam logic [IDX_W-1:0] IDLE_IDX  = IDX_W'(NUM_STAGES);

    state_t                state_q;
    state_t                state_d;
    logic [NUM_STAGES-1:0] rst_out_d;
    logic                  busy_d;
    logic                  done_d;
    logic [IDX_W-1:0]      stage_idx_d;

    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_term;
    logic                  cnt_at_term;
    logic                  cnt_clear;
    logic                  cnt_en;

    // Terminal value depends only on the current state, keeping it off the
    // combinational path through the next-state logic.
    assign cnt_term = (state_q == HOLD) ? HOLD_TERM : GAP_TERM;

    tc_counter #(
        .CNT_W (CNT_W)
    ) u_tc_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .en      (cnt_en),
        .term    (cnt_term),
        .count   (cnt),
        .at_term (cnt_at_term)
    );

    // Next-state and next-output logic; a software request restarts the
    // sequence from any state and beats a release due on the same edge.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        rst_out_d   = rst_out;
        done_d      = 1'b0;
        stage_idx_d = stage_idx;
        cnt_en      = 1'b0;
        cnt_clear   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sw_rst_req) begin
                    state_d     = HOLD;
                    rst_out_d   = '1;
                    stage_idx_d = '0;
                    cnt_clear   = 1'b1;
                end
            end
            HOLD, GAP: begin
                cnt_en = 1'b1;
                if (sw_rst_req) begin
                    state_d     = HOLD;
                    rst_out_d   = '1;
                    stage_idx_d = '0;
                    cnt_clear   = 1'b1;
                end else if (cnt_at_term) begin
                    // Bits release in index order, so shifting in a zero
                    // clears exactly bit stage_idx.
                    rst_out_d = rst_out << 1;
                    cnt_clear = 1'b1;
                    if (stage_idx == LAST_IDX) begin
                        state_d     = IDLE;
                        done_d      = 1'b1;
                        stage_idx_d = IDLE_IDX;
                    end else begin
                        state_d     = GAP;
                        stage_idx_d = stage_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = |rst_out_d;
    end

    // State and output registers; global reset restarts in HOLD with all
    // domains asserted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= HOLD;
            rst_out   <= '1;
            busy      <= 1'b1;
            done      <= 1'b0;
            stage_idx <= '0;
        end else begin
            state_q   <= state_d;
            rst_out   <= rst_out_d;
            busy      <= busy_d;
            done      <= done_d;
            stage_idx <= stage_idx_d;
        end
    end

    // The interval counter is cleared at every terminal count.
    cnt_bound_a : assert property (@(posedge clk) disable iff (reset) cnt <= CNT_MAX);

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: default-parameter instance checked
// cycle by cycle against a closed-form release-time model, plus a
// single-stage, single-cycle corner instance.
module tb_rst_seq_ctrl;

    localparam int NUM  = 4;
    localparam int HOLD = 16;
    localparam int GAP  = 4;

    typedef struct packed {
        logic [3:0] rst_out;
        logic       busy;
        logic       done;
        logic [2:0] stage_idx;
    } obs_t;

    typedef struct packed {
        logic rst_out;
        logic busy;
        logic done;
        logic stage_idx;
    } cobs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       sw_rst_req;
    logic [3:0] rst_out;
    logic       busy;
    logic       done;
    logic [2:0] stage_idx;

    logic       c_reset;
    logic       c_sw_rst_req;
    logic [0:0] c_rst_out;
    logic       c_busy;
    logic       c_done;
    logic [0:0] c_stage_idx;

    int   n_checks = 0;
    int   n_errors = 0;
    int   p        = 0;   // counting edges since the last reset/sw request
    obs_t sb_q[$];
    cobs_t csb_q[$];

    always #5 clk = ~clk;

    rst_seq_ctrl #(
        .NUM_STAGES  (NUM),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP),
        .CNT_W       (8)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .sw_rst_req (sw_rst_req),
        .rst_out    (rst_out),
        .busy       (busy),
        .done       (done),
        .stage_idx  (stage_idx)
    );

    rst_seq_ctrl #(
        .NUM_STAGES  (1),
        .HOLD_CYCLES (1),
        .GAP_CYCLES  (1),
        .CNT_W       (8)
    ) u_corner (
        .clk        (clk),
        .reset      (c_reset),
        .sw_rst_req (c_sw_rst_req),
        .rst_out    (c_rst_out),
        .busy       (c_busy),
        .done       (c_done),
        .stage_idx  (c_stage_idx)
    );

    // Expected outputs after p counting edges: domain i is first low after
    // HOLD + i*GAP counting edges; done marks the edge the last one drops.
    function automatic obs_t model(input int pos);
        obs_t       e;
        int         r;
        logic [3:0] m;
        if (pos < HOLD) begin
            r = 0;
        end else begin
            r = 1 + (pos - HOLD) / GAP;
            if (r > NUM) r = NUM;
        end
        m           = 4'b1111;
        e.rst_out   = m << r;
        e.busy      = (r < NUM);
        e.done      = (pos == HOLD + (NUM - 1) * GAP);
        e.stage_idx = 3'(r);
        return e;
    endfunction

    // Drive one cycle of stimulus, queue its expected result, then step to
    // 1 time unit after the edge where the result appears.
    task automatic drive(input logic r, input logic s);
        reset      = r;
        sw_rst_req = s;
        if (r || s) p = 0;
        else        p = p + 1;
        sb_q.push_back(model(p));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t e, o;
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 1'b0);
            e = sb_q.pop_front();
            o = {rst_out, busy, done, stage_idx};
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL reset cyc %0d: got %b required %b", c, o, e);
            end
        end
    endtask

    task automatic test_global_release();
        obs_t e, o;
        int   exp_done = 0;
        int   got_done = 0;
        for (int c = 0; c < 40; c++) begin
            drive(1'b0, 1'b0);
            e = sb_q.pop_front();
            o = {rst_out, busy, done, stage_idx};
            exp_done += int'(e.done);
            got_done += int'(o.done === 1'b1);
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL global_release E%0d: got %b required %b", c, o, e);
            end
        end
        n_checks++;
        if (got_done != exp_done) begin
            n_errors++;
            $display("FAIL global_release done_count: got %0d required %0d", got_done, exp_done);
        end
    endtask

    task automatic test_sw_from_idle();
        obs_t e, o;
        int   exp_done = 0;
        int   got_done = 0;
        for (int c = 0; c < 36; c++) begin
            drive(1'b0, c == 0);
            e = sb_q.pop_front();
            o = {rst_out, busy, done, stage_idx};
            exp_done += int'(e.done);
            got_done += int'(o.done === 1'b1);
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL sw_from_idle cyc %0d: got %b required %b", c, o, e);
            end
        end
        n_checks++;
        if (got_done != exp_done) begin
            n_errors++;
            $display("FAIL sw_from_idle done_count: got %0d required %0d", got_done, exp_done);
        end
    endtask

    // Second request lands while two domains are already released.
    task automatic test_sw_mid_release();
        obs_t e, o;
        int   exp_done = 0;
        int   got_done = 0;
        for (int c = 0; c < 53; c++) begin
            drive(1'b0, (c == 0) || (c == 22));
            e = sb_q.pop_front();
            o = {rst_out, busy, done, stage_idx};
            if (c == 21 && e.rst_out != 4'b1100) begin
                $display("note: sw_mid_release stimulus misaligned");
            end
            exp_done += int'(e.done);
            got_done += int'(o.done === 1'b1);
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL sw_mid_release cyc %0d: got %b required %b", c, o, e);
            end
        end
        n_checks++;
        if (got_done != exp_done) begin
            n_errors++;
            $display("FAIL sw_mid_release done_count: got %0d required %0d", got_done, exp_done);
        end
    endtask

    // Request coincides with the edge that would release domain 3.
    task automatic test_collision();
        obs_t e, o;
        int   exp_done = 0;
        int   got_done = 0;
        for (int c = 0; c < 59; c++) begin
            drive(1'b0, (c == 0) || (c == 28));
            e = sb_q.pop_front();
            o = {rst_out, busy, done, stage_idx};
            exp_done += int'(e.done);
            got_done += int'(o.done === 1'b1);
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL collision cyc %0d: got %b required %b", c, o, e);
            end
        end
        n_checks++;
        if (got_done != exp_done) begin
            n_errors++;
            $display("FAIL collision done_count: got %0d required %0d", got_done, exp_done);
        end
    endtask

    // Reset lands while only domain 3 is held, then periodic reset.
    task automatic test_reset_periodic();
        obs_t e, o;
        int   exp_done = 0;
        int   got_done = 0;
        for (int c = 0; c < 26; c++) begin
            drive(1'b0, c == 0);
            e = sb_q.pop_front();
            o = {rst_out, busy, done, stage_idx};
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL reset_mid pre cyc %0d: got %b required %b", c, o, e);
            end
        end
        for (int c = 0; c < 301; c++) begin
            drive(((c / 77) % 2) == 0, 1'b0);
            e = sb_q.pop_front();
            o = {rst_out, busy, done, stage_idx};
            exp_done += int'(e.done);
            got_done += int'(o.done === 1'b1);
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL reset_periodic cyc %0d: got %b required %b", c, o, e);
            end
        end
        n_checks++;
        if (got_done != exp_done) begin
            n_errors++;
            $display("FAIL reset_periodic done_count: got %0d required %0d", got_done, exp_done);
        end
    endtask

    // NUM_STAGES=1, HOLD=1, GAP=1: release and done on the first free edge.
    task automatic test_corner();
        logic  stim_r [10];
        logic  stim_s [10];
        cobs_t exp_v  [10];
        cobs_t e, o;
        stim_r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        stim_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_v  = '{4'b1100, 4'b1100, 4'b1100, 4'b0011, 4'b0001,
                   4'b1100, 4'b0011, 4'b0001, 4'b1100, 4'b0011};
        for (int c = 0; c < 10; c++) begin
            c_reset      = stim_r[c];
            c_sw_rst_req = stim_s[c];
            csb_q.push_back(exp_v[c]);
            @(posedge clk);
            #1;
            e = csb_q.pop_front();
            o = {c_rst_out, c_busy, c_done, c_stage_idx};
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL corner cyc %0d: got %b required %b", c, o, e);
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        sw_rst_req   = 1'b0;
        c_reset      = 1'b1;
        c_sw_rst_req = 1'b0;
        test_reset();
        test_global_release();
        test_sw_from_idle();
        test_sw_mid_release();
        test_collision();
        test_reset_periodic();
        test_corner();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
